// File: rtl/mioc_flop_seq.sv
// Pattern sequencer for exercising a flop-based register: applies stored
// {in1..in4} stimulus, waits a programmable dwell, then checks {q,qbar}.
module mioc_flop_seq #(
    parameter int DEPTH   = 16,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [3:0]         wr_addr,
    input  logic [5:0]         wr_data,
    input  logic [3:0]         num_pat,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               start,
    input  logic               abort,
    input  logic               q,
    input  logic               qbar,
    output logic               in1,
    output logic               in2,
    output logic               in3,
    output logic               in4,
    output logic               busy,
    output logic               done,
    output logic [7:0]         err_cnt,
    output logic               err_flag,
    output logic [3:0]         first_err_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        WAIT   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_MAX = 4'(DEPTH - 1);

    state_t             state_reg, state_next;
    logic [3:0]         idx_reg, idx_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [3:0]         stim_reg, stim_next;
    logic               done_reg, done_next;
    logic [7:0]         err_cnt_reg, err_cnt_next;
    logic               err_flag_reg, err_flag_next;
    logic [3:0]         first_err_reg, first_err_next;

    logic [5:0]         mem [DEPTH];
    logic [5:0]         rd_data;
    logic [3:0]         last_idx;
    logic               mismatch;

    // Pattern memory is deliberately outside the reset domain so a reset
    // between runs keeps the loaded patterns.
    always_ff @(posedge clk) begin
        if (wr_en && (state_reg == IDLE) && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = mem[idx_reg];
    assign last_idx = (32'(num_pat) > (DEPTH - 1)) ? LAST_MAX : num_pat;
    assign mismatch = ({q, qbar} != rd_data[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            stim_reg      <= '0;
            done_reg      <= 1'b0;
            err_cnt_reg   <= '0;
            err_flag_reg  <= 1'b0;
            first_err_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            stim_reg      <= stim_next;
            done_reg      <= done_next;
            err_cnt_reg   <= err_cnt_next;
            err_flag_reg  <= err_flag_next;
            first_err_reg <= first_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        stim_next      = stim_reg;
        done_next      = done_reg;
        err_cnt_next   = err_cnt_reg;
        err_flag_next  = err_flag_reg;
        first_err_next = first_err_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next     = APPLY;
                    idx_next       = '0;
                    done_next      = 1'b0;
                    err_cnt_next   = '0;
                    err_flag_next  = 1'b0;
                    first_err_next = '0;
                end
            end
            APPLY: begin
                stim_next  = rd_data[5:2];
                cnt_next   = dwell;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_next = err_cnt_reg + 8'd1;
                    end
                    err_flag_next = 1'b1;
                    if (!err_flag_reg) begin
                        first_err_next = idx_reg;
                    end
                end
                if (idx_reg == last_idx) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = APPLY;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over any in-flight update but keeps the error record.
        if (abort && (state_reg != IDLE)) begin
            state_next     = IDLE;
            stim_next      = '0;
            idx_next       = idx_reg;
            cnt_next       = cnt_reg;
            done_next      = done_reg;
            err_cnt_next   = err_cnt_reg;
            err_flag_next  = err_flag_reg;
            first_err_next = first_err_reg;
        end
    end

    assign {in1, in2, in3, in4} = stim_reg;
    assign busy                 = (state_reg != IDLE);
    assign done                 = done_reg;
    assign err_cnt              = err_cnt_reg;
    assign err_flag             = err_flag_reg;
    assign first_err_idx        = first_err_reg;

endmodule
